// File: rtl/core_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package core_icache_pkg;
  localparam int ICACHE_LINE_BYTES = 64;
  localparam int ICACHE_BEATS      = 8;

  typedef enum logic [1:0] {IDLE, REQ, FILL, FLUSH} icache_state_t;
endpackage

// File: rtl/core_icache_data_ram.sv
// Line storage: asynchronous full-line read, one 64-bit word written per clock.
module icache_data_ram
  import core_icache_pkg::*;
#(
  parameter int LINES = 64,
  localparam int IDXW = $clog2(LINES)
) (
  input  logic                           i_clk,
  input  logic                           we,
  input  logic [IDXW-1:0]                widx,
  input  logic [2:0]                     wbeat,
  input  logic [63:0]                    wdata,
  input  logic [IDXW-1:0]                ridx,
  output logic [ICACHE_LINE_BYTES*8-1:0] rline
);
  logic [ICACHE_BEATS-1:0][63:0] mem [LINES];

  always_ff @(posedge i_clk)
    if (we) mem[widx][wbeat] <= wdata;

  assign rline = mem[ridx];
endmodule

// File: rtl/core_icache.sv
// Direct-mapped I-cache: combinational hit path, 8-beat line refill, fence.i flush.
module core_icache
  import core_icache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_addr,
  output logic [31:0] o_data,
  output logic        o_data_ready,
  input  logic        i_flush,
  output logic        o_flush_done,
  output logic        o_mem_req,
  output logic [63:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [63:0] i_mem_rdata,
  input  logic        i_mem_err,
  output logic        o_bus_err
);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 64 - 6 - IDXW;

  icache_state_t   state, state_n;
  logic [63:0]     miss_addr;
  logic [2:0]      beat;
  logic            flush_pending;
  logic [LINES-1:0] valid;
  logic [TAGW-1:0] tag_ram [LINES];

  logic [IDXW-1:0] idx, fidx;
  logic [TAGW-1:0] tag;
  logic            hit, pend, ram_we, fill_done;
  logic [ICACHE_LINE_BYTES*8-1:0]    rline;
  logic [ICACHE_LINE_BYTES*8+31:0]   ext;
  logic [8:0]      bitoff;
  logic [31:0]     win;
  logic            unused;

  assign unused = i_addr[0];
  assign idx    = i_addr[6 +: IDXW];
  assign tag    = i_addr[63 -: TAGW];
  assign fidx   = miss_addr[6 +: IDXW];
  assign hit    = (state == IDLE) & valid[idx] & (tag_ram[idx] == tag);
  assign pend   = flush_pending | i_flush;

  icache_data_ram #(.LINES(LINES)) u_data (
    .i_clk (i_clk),
    .we    (ram_we),
    .widx  (fidx),
    .wbeat (beat),
    .wdata (i_mem_rdata),
    .ridx  (idx),
    .rline (rline)
  );

  // Zero-extend past the line end so a window at 0x3E carries 16'h0 on top.
  assign ext    = {32'h0, rline};
  assign bitoff = {i_addr[5:1], 1'b0, 3'b000};
  assign win    = ext[bitoff +: 32];

  assign o_data_ready = hit;
  assign o_data       = hit ? win : 32'h0;
  assign o_mem_req    = (state == REQ);
  assign o_mem_addr   = (state == REQ) ? miss_addr : 64'h0;

  always_comb begin
    state_n      = state;
    ram_we       = 1'b0;
    fill_done    = 1'b0;
    o_bus_err    = 1'b0;
    o_flush_done = 1'b0;
    case (state)
      IDLE:  if (i_flush) state_n = FLUSH;
             else if (!hit) state_n = REQ;
      REQ:   if (i_mem_gnt) state_n = FILL;
      FILL:  if (i_mem_rvalid) begin
               if (i_mem_err) begin
                 o_bus_err = 1'b1;
                 state_n   = pend ? FLUSH : IDLE;
               end else begin
                 ram_we = 1'b1;
                 if (beat == 3'(ICACHE_BEATS - 1)) begin
                   fill_done = 1'b1;
                   state_n   = pend ? FLUSH : IDLE;
                 end
               end
             end
      FLUSH: begin
               o_flush_done = 1'b1;
               state_n      = IDLE;
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      miss_addr     <= 64'h0;
      beat          <= 3'd0;
      flush_pending <= 1'b0;
      valid         <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (!i_flush && !hit) begin
          miss_addr  <= {i_addr[63:6], 6'h0};
          valid[idx] <= 1'b0;
        end
        REQ: begin
          if (i_mem_gnt) beat <= 3'd0;
          if (i_flush) flush_pending <= 1'b1;
        end
        FILL: begin
          if (i_flush) flush_pending <= 1'b1;
          if (ram_we) beat <= beat + 3'd1;
          if (fill_done) valid[fidx] <= 1'b1;
        end
        FLUSH: begin
          valid         <= '0;
          flush_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset; the valid vector gates every lookup.
  always_ff @(posedge i_clk)
    if (fill_done) tag_ram[fidx] <= miss_addr[63 -: TAGW];
endmodule
